// File: rtl/mips_cpu_pkg.sv
// Shared MIPS CPU definitions: sequencer state encoding plus the opcode, funct and
// REGIMM field values the controller decodes. Used by the sequencer, the
// instruction classifier and the controller.
package mips_cpu_pkg;

  typedef enum logic [2:0] {
    HALT   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC1  = 3'd3,
    EXEC2  = 3'd4
  } cpu_state_t;

  // Primary opcodes, IR[31:26]
  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_REGIMM  = 6'h01;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_BLEZ    = 6'h06;
  localparam logic [5:0] OP_BGTZ    = 6'h07;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_SLTI    = 6'h0A;
  localparam logic [5:0] OP_SLTIU   = 6'h0B;
  localparam logic [5:0] OP_ANDI    = 6'h0C;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_XORI    = 6'h0E;
  localparam logic [5:0] OP_LUI     = 6'h0F;
  localparam logic [5:0] OP_LB      = 6'h20;
  localparam logic [5:0] OP_LH      = 6'h21;
  localparam logic [5:0] OP_LWL     = 6'h22;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_LBU     = 6'h24;
  localparam logic [5:0] OP_LHU     = 6'h25;
  localparam logic [5:0] OP_LWR     = 6'h26;
  localparam logic [5:0] OP_SB      = 6'h28;
  localparam logic [5:0] OP_SH      = 6'h29;
  localparam logic [5:0] OP_SW      = 6'h2B;

  // SPECIAL funct codes, IR[5:0]
  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_SRL   = 6'h02;
  localparam logic [5:0] FN_SRA   = 6'h03;
  localparam logic [5:0] FN_SLLV  = 6'h04;
  localparam logic [5:0] FN_SRLV  = 6'h06;
  localparam logic [5:0] FN_SRAV  = 6'h07;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_JALR  = 6'h09;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_XOR   = 6'h26;
  localparam logic [5:0] FN_SLT   = 6'h2A;
  localparam logic [5:0] FN_SLTU  = 6'h2B;

  // REGIMM rt codes, IR[20:16]
  localparam logic [4:0] RT_BLTZ   = 5'd0;
  localparam logic [4:0] RT_BGEZ   = 5'd1;
  localparam logic [4:0] RT_BLTZAL = 5'd16;
  localparam logic [4:0] RT_BGEZAL = 5'd17;

endpackage

// File: rtl/mips_cpu_instr_class.sv
// Combinational instruction classifier for the state sequencer.
// Ports:
//   opcode, fncode, regimm : instruction fields IR[31:26], IR[5:0], IR[20:16]
//   is_mem                 : load or store (may stall on waitrequest in EXEC1)
//   is_two_cycle           : needs EXEC2 (loads, REGIMM with rt >= 2)
//   is_muldiv_dep          : HI/LO access or mult/div start (stalls on muldiv_busy)
//   is_legal               : instruction is decoded by the controller
module mips_cpu_instr_class
  import mips_cpu_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] fncode,
  input  logic [4:0] regimm,
  output logic       is_mem,
  output logic       is_two_cycle,
  output logic       is_muldiv_dep,
  output logic       is_legal
);

  always_comb begin
    is_mem        = 1'b0;
    is_two_cycle  = 1'b0;
    is_muldiv_dep = 1'b0;
    is_legal      = 1'b0;
    case (opcode)
      OP_SPECIAL: begin
        case (fncode)
          FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV, FN_JR, FN_JALR,
          FN_ADDU, FN_SUBU, FN_AND, FN_OR, FN_XOR, FN_SLT, FN_SLTU: is_legal = 1'b1;
          FN_MFHI, FN_MTHI, FN_MFLO, FN_MTLO, FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: begin
            is_legal      = 1'b1;
            is_muldiv_dep = 1'b1;
          end
          default: ;
        endcase
      end
      OP_REGIMM: begin
        is_legal     = regimm inside {RT_BLTZ, RT_BGEZ, RT_BLTZAL, RT_BGEZAL};
        // Linking variants write $ra in a second cycle
        is_two_cycle = (regimm >= 5'd2);
      end
      OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ, OP_ADDIU, OP_SLTI, OP_SLTIU,
      OP_ANDI, OP_ORI, OP_XORI, OP_LUI: is_legal = 1'b1;
      OP_LB, OP_LH, OP_LWL, OP_LW, OP_LBU, OP_LHU, OP_LWR: begin
        is_legal     = 1'b1;
        is_mem       = 1'b1;
        is_two_cycle = 1'b1;
      end
      OP_SB, OP_SH, OP_SW: begin
        is_legal = 1'b1;
        is_mem   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mips_cpu_state_sequencer.sv
// Multicycle state register and next-state logic for the MIPS CPU.
// Sequences HALT/FETCH/DECODE/EXEC1/EXEC2, stalls on waitrequest and muldiv_busy,
// halts on next-PC == HALT_ADDR or on an illegal instruction.
// Ports:
//   clk, reset            : clock, asynchronous active-high reset
//   opcode/fncode/regimm  : instruction fields, meaningful from EXEC1
//   waitrequest           : Avalon memory stall
//   muldiv_busy           : mult/div unit busy
//   pc                    : current PC (address of next fetch)
//   state                 : 0=HALT 1=FETCH 2=DECODE 3=EXEC1 4=EXEC2 (registered)
//   active                : CPU running (registered)
//   illegal               : sticky illegal-instruction flag (registered)
//   instr_done            : combinational pulse on the last cycle of an instruction
//   cycle_count/stall_count : performance counters
// Build option: define MIPS_SEQ_PERF_CNT_EN to implement the counters; otherwise
// they read as zero and no counter flops exist.
module mips_cpu_state_sequencer
  import mips_cpu_pkg::*;
#(
  parameter logic [31:0] HALT_ADDR = 32'h0000_0000,
  parameter int unsigned CNT_W     = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic [5:0]       fncode,
  input  logic [4:0]       regimm,
  input  logic             waitrequest,
  input  logic             muldiv_busy,
  input  logic [31:0]      pc,
  output logic [2:0]       state,
  output logic             active,
  output logic             illegal,
  output logic             instr_done,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] stall_count
);

  cpu_state_t state_q;
  logic       boot_q;

  logic is_mem, is_two_cycle, is_muldiv_dep, is_legal;
  logic exec1_stall;
  logic halt_next;

  mips_cpu_instr_class u_instr_class (
    .opcode        (opcode),
    .fncode        (fncode),
    .regimm        (regimm),
    .is_mem        (is_mem),
    .is_two_cycle  (is_two_cycle),
    .is_muldiv_dep (is_muldiv_dep),
    .is_legal      (is_legal)
  );

  always_comb begin
    exec1_stall = (state_q == EXEC1) &&
                  ((waitrequest && is_mem) || (muldiv_busy && is_muldiv_dep));
    // Stall outranks illegal, which outranks the two-cycle path
    instr_done  = (state_q == EXEC2) ||
                  ((state_q == EXEC1) && !exec1_stall && is_legal && !is_two_cycle);
    // pc already carries the delay-slot update on the completion edge
    halt_next   = (pc == HALT_ADDR);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= HALT;
      boot_q  <= 1'b1;
      active  <= 1'b0;
      illegal <= 1'b0;
    end else begin
      unique case (state_q)
        HALT: begin
          // Only the first HALT after reset boots; later HALTs are terminal
          if (boot_q) begin
            state_q <= FETCH;
            boot_q  <= 1'b0;
            active  <= 1'b1;
          end
        end
        FETCH:  if (!waitrequest) state_q <= DECODE;
        DECODE: state_q <= EXEC1;
        EXEC1: begin
          if (!exec1_stall) begin
            if (!is_legal) begin
              state_q <= HALT;
              illegal <= 1'b1;
              active  <= 1'b0;
            end else if (is_two_cycle) begin
              state_q <= EXEC2;
            end else begin
              state_q <= halt_next ? HALT : FETCH;
              active  <= !halt_next;
            end
          end
        end
        EXEC2: begin
          state_q <= halt_next ? HALT : FETCH;
          active  <= !halt_next;
        end
        default: begin
          state_q <= HALT;
          active  <= 1'b0;
        end
      endcase
    end
  end

  assign state = state_q;

`ifdef MIPS_SEQ_PERF_CNT_EN
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  logic [CNT_W-1:0] cycle_cnt_q;
  logic [CNT_W-1:0] stall_cnt_q;
  logic             stall_cycle;

  assign stall_cycle = ((state_q == FETCH) && waitrequest) || exec1_stall;

  // active is low in HALT, so both counters freeze there
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (active)      cycle_cnt_q <= cycle_cnt_q + CntOne;
      if (stall_cycle) stall_cnt_q <= stall_cnt_q + CntOne;
    end
  end

  assign cycle_count = cycle_cnt_q;
  assign stall_count = stall_cnt_q;
`else
  assign cycle_count = '0;
  assign stall_count = '0;
`endif

endmodule
